shift_rows_pipe: RTL
====================

Name: shift_rows_pipe

Overview:
- Parametrised, registered successor to the combinational AES ShiftRows stage.
- Supports Rijndael block widths NB = 4, 6 or 8 columns, and forward or inverse row shifting selected per transaction.
- Valid/ready handshake on input and output, with an output FIFO of FIFO_DEPTH entries.
- Sits between SubBytes and MixColumns in the pipelined round datapath.

Parameters:
- NB, 4, number of 32-bit state columns; legal values 4, 6, 8. Any other value is an elaboration error ($fatal).
- FIFO_DEPTH, 2, output buffer entries; a power of 2, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a state word.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  32*NB  state, column-major.
- in_inv  input  1  1 = InvShiftRows, 0 = ShiftRows.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_data  output  32*NB  shifted state.
- out_inv  output  1  in_inv echoed with its data.
- count  output  $clog2(FIFO_DEPTH+1)  occupied entries.

Behaviour:
- Byte mapping: s[r][c] = in_data[8*(4*NB-1-(4*c+r)) +: 8], so byte 0 is at the MSB. The same mapping applies to out_data.
- Row offsets C0..C3:
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward shift: s'[r][c] = s[r][(c+Cr) mod NB].
- Inverse shift: s'[r][c] = s[r][(c-Cr) mod NB].
- Permutation is combinational on in_data. The result, plus in_inv, is written into the FIFO on a handshake (in_valid && in_ready).
- out_data and out_inv come directly from the FIFO head storage. There is no input-to-output bypass.
- Latency: a word accepted at edge t has out_valid=1 after edge t, i.e. one cycle, when the FIFO was empty. Output order equals input order.
- in_ready = (count < FIFO_DEPTH) || out_ready. This combinational path from out_ready is intentional.
- out_valid = (count != 0).
- Push and pop in the same cycle: count unchanged, read/write pointers both advance. This is legal when full.
- Empty FIFO: no pop; out_ready is ignored.
- Full FIFO with out_ready=0: in_ready=0; in_data is not captured and upstream holds it.
- Pointers wrap modulo FIFO_DEPTH.
- count increments on push only, decrements on pop only.
- Reset values (asynchronous on rst rising): count=0, out_valid=0, out_data=0, out_inv=0, both pointers=0. FIFO storage is not reset.
- Reset mid-operation discards all buffered words; none appear after reset release.
- in_valid while rst=1 is ignored.

Optional Feature:
- Macro: SHIFT_ROWS_INV_EN.
- Defined: in_inv selects inverse shifting as above and is stored and echoed on out_inv.
- Undefined: in_inv is ignored, only forward shifting is built, and out_inv is tied to 0.

Decomposition:
- Package shift_rows_pkg holds:
  - typedef byte_t (logic [7:0]).
  - constant MAX_NB = 8.
  - function row_offset(nb, r) returning Cr.
  - function shift_state(nb, data, inv) implementing the permutation.
- One sub-module, shift_rows_fifo: a synchronous FIFO parametrised by WIDTH and DEPTH, with push/pop/count and asynchronous reset.
- The top level holds the permutation and the handshake glue.

Test Plan:
- Forward, NB=4, macro defined:
  - Stimulus: in_data = d42711ae_e0bf98f1_b8b45de5_1e415230, in_inv=0, out_ready=1.
  - Expected: one cycle later out_valid=1, out_data = d4bf5d30_e0b452ae_b84111f1_1e2798e5, out_inv=0.
- Inverse, NB=4:
  - Stimulus: in_data = d4bf5d30_e0b452ae_b84111f1_1e2798e5, in_inv=1.
  - Expected: out_data = d42711ae_e0bf98f1_b8b45de5_1e415230, out_inv=1.
- Backpressure, FIFO_DEPTH=2:
  - Stimulus: out_ready=0; offer three distinct words.
  - Expected: first two accepted, then count=2 and in_ready=0; third held.
  - Then set out_ready=1. Expected: three outputs in order, count returns to 0.
- Full, simultaneous push and pop:
  - Stimulus: count=2, in_valid=1, out_ready=1 for 4 cycles.
  - Expected: in_ready=1 and count=2 throughout; outputs in order.
- NB=8, forward:
  - Stimulus: in_data bytes 0x00..0x1F (byte k = k).
  - Expected: out_data MSB word = 00050e13 (offset 4 on row 3); last word 1c010a0f.
- Reset mid-operation:
  - Stimulus: 2 words buffered, pulse rst between clock edges.
  - Expected: out_valid=0, count=0 and out_data=0 immediately; after release, no stale word is ever output.
  - Also build with SHIFT_ROWS_INV_EN undefined and in_inv=1. Expected: forward result, out_inv=0.

Source files
------------

// File: rtl/shift_rows_pkg.sv
// Shared types and the Rijndael ShiftRows permutation for NB = 4, 6 or 8 columns.
package shift_rows_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned MAX_NB = 8;
    localparam int unsigned MAX_W  = 32 * MAX_NB;

    // Wide blocks (NB = 8) skip offset 2 and use 1, 3, 4 on rows 1..3.
    function automatic int unsigned row_offset(input int unsigned nb, input int unsigned r);
        if (nb == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    // State occupies the low 32*nb bits of data; byte 0 sits at the top of that field.
    function automatic logic [MAX_W-1:0] shift_state(input int unsigned nb,
                                                     input logic [MAX_W-1:0] data,
                                                     input logic inv);
        logic [MAX_W-1:0] res;
        byte_t            b;
        int unsigned      off;
        int unsigned      src;
        res = '0;
        for (int unsigned c = 0; c < MAX_NB; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                if (c < nb) begin
                    off = row_offset(nb, r);
                    src = inv ? (c + nb - off) % nb : (c + off) % nb;
                    b   = data[8*(4*nb-1-(4*src+r)) +: 8];
                    res[8*(4*nb-1-(4*c+r)) +: 8] = b;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_rows_fifo.sv
// Synchronous FIFO with asynchronous active-high reset; reads as zero while empty.
module shift_rows_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             empty, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows stage with valid/ready handshake and output FIFO.
// Define SHIFT_ROWS_INV_EN to build per-transaction inverse shifting (echoed on out_inv).
module shift_rows_pipe
    import shift_rows_pkg::*;
#(
    parameter int unsigned NB         = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [32*NB-1:0]                in_data,
    input  logic                            in_inv,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [32*NB-1:0]                out_data,
    output logic                            out_inv,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int unsigned W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $fatal(1, "shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "shift_rows_pipe: FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic [W-1:0] shifted;
    logic         push, pop, full;

`ifdef SHIFT_ROWS_INV_EN
    localparam int unsigned FW = W + 1;
    logic [FW-1:0] wdata, rdata;

    assign shifted  = W'(shift_state(NB, MAX_W'(in_data), in_inv));
    assign wdata    = {in_inv, shifted};
    assign out_inv  = rdata[W];
    assign out_data = rdata[W-1:0];
`else
    localparam int unsigned FW = W;
    logic [FW-1:0] wdata, rdata;
    logic          unused_inv;

    assign unused_inv = in_inv;
    assign shifted    = W'(shift_state(NB, MAX_W'(in_data), 1'b0));
    assign wdata      = shifted;
    assign out_inv    = 1'b0;
    assign out_data   = rdata;
`endif

    // out_ready feeds in_ready combinationally so a full FIFO can stream.
    assign in_ready  = !full || out_ready;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    shift_rows_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count),
        .full  (full)
    );

endmodule
